// File: rtl/mem_pkg.sv
// Shared types and address helpers for the dual-write, dual-read memory.
// Provides the byte width, FSM state type and address check/index functions.
package mem_pkg;

    localparam int BYTE_W = 8;
    localparam int AW_MAX = 64;

    typedef logic [AW_MAX-1:0] addr_t;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Aligned, in range, and no stray bits above the index field.
    function automatic logic addr_ok(addr_t a, int depth, int ofs, int iw);
        addr_t lo_mask;
        addr_t ix_mask;
        addr_t ix;
        lo_mask = (addr_t'(1) << ofs) - addr_t'(1);
        ix_mask = (addr_t'(1) << iw) - addr_t'(1);
        ix      = (a >> ofs) & ix_mask;
        return ((a & lo_mask) == '0)
            && (ix < addr_t'(depth))
            && ((a >> (ofs + iw)) == '0);
    endfunction

    function automatic addr_t idx(addr_t a, int ofs, int iw);
        return (a >> ofs) & ((addr_t'(1) << iw) - addr_t'(1));
    endfunction

endpackage

// File: rtl/mem_2w2r_if.sv
// Bus bundle for mem_2w2r: two byte-masked write ports, two read ports,
// read data/valid, ready and error. master drives requests, slave answers.
interface mem_2w2r_if #(
    parameter int WIDTH = 32
);
    localparam int NB = WIDTH / 8;

    logic             wen1;
    logic [NB-1:0]    wmask1;
    logic [WIDTH-1:0] addrw1;
    logic [WIDTH-1:0] dataw1;
    logic             wen2;
    logic [NB-1:0]    wmask2;
    logic [WIDTH-1:0] addrw2;
    logic [WIDTH-1:0] dataw2;
    logic             rena;
    logic [WIDTH-1:0] addra;
    logic             renb;
    logic [WIDTH-1:0] addrb;
    logic [WIDTH-1:0] outa;
    logic [WIDTH-1:0] outb;
    logic             valida;
    logic             validb;
    logic             ready;
    logic             err;

    modport master (
        output wen1, wmask1, addrw1, dataw1,
        output wen2, wmask2, addrw2, dataw2,
        output rena, addra, renb, addrb,
        input  outa, outb, valida, validb, ready, err
    );

    modport slave (
        input  wen1, wmask1, addrw1, dataw1,
        input  wen2, wmask2, addrw2, dataw2,
        input  rena, addra, renb, addrb,
        output outa, outb, valida, validb, ready, err
    );

endinterface

// File: rtl/mem_wmerge.sv
// Per-lane byte merge of up to two writes onto an existing word.
// Ports: cur (old word), mask/data/hit per write port, word (merged result).
module mem_wmerge
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]        cur,
    input  logic [WIDTH/BYTE_W-1:0] mask1,
    input  logic [WIDTH-1:0]        data1,
    input  logic                    hit1,
    input  logic [WIDTH/BYTE_W-1:0] mask2,
    input  logic [WIDTH-1:0]        data2,
    input  logic                    hit2,
    output logic [WIDTH-1:0]        word
);
    localparam int NB = WIDTH / BYTE_W;

    // Port 2 takes priority on lanes both ports enable.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign word[i*BYTE_W +: BYTE_W] =
            (hit2 && mask2[i]) ? data2[i*BYTE_W +: BYTE_W] :
            (hit1 && mask1[i]) ? data1[i*BYTE_W +: BYTE_W] :
                                 cur[i*BYTE_W +: BYTE_W];
    end

endmodule

// File: rtl/mem_2w2r.sv
// Dual-write, dual-read word memory with zero-fill after reset.
// Ports: clk, rst (async active-low), bus (mem_2w2r_if slave).
module mem_2w2r
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic       clk,
    input  logic       rst,
    mem_2w2r_if.slave  bus
);
    localparam int NB  = WIDTH / BYTE_W;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    typedef logic [IW-1:0] idx_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t state_q, state_d;
    idx_t   cnt_q, cnt_d;
    logic   run;

    logic ok1, ok2, oka, okb;
    idx_t i1, i2, ia, ib;
    logic hit1, hit2, same;
    logic [WIDTH-1:0] w1_word, w2_word, ra_word, rb_word;

    logic [WIDTH-1:0] outa_q, outb_q;
    logic valida_q, validb_q, err_q;

    assign run = (state_q == RUN);

    assign ok1 = addr_ok(AW_MAX'(bus.addrw1), DEPTH, OFS, IW);
    assign ok2 = addr_ok(AW_MAX'(bus.addrw2), DEPTH, OFS, IW);
    assign oka = addr_ok(AW_MAX'(bus.addra), DEPTH, OFS, IW);
    assign okb = addr_ok(AW_MAX'(bus.addrb), DEPTH, OFS, IW);

    assign i1 = idx_t'(idx(AW_MAX'(bus.addrw1), OFS, IW));
    assign i2 = idx_t'(idx(AW_MAX'(bus.addrw2), OFS, IW));
    assign ia = idx_t'(idx(AW_MAX'(bus.addra), OFS, IW));
    assign ib = idx_t'(idx(AW_MAX'(bus.addrb), OFS, IW));

    assign hit1 = run && bus.wen1 && ok1;
    assign hit2 = run && bus.wen2 && ok2;
    assign same = hit1 && hit2 && (i1 == i2);

    // When both ports target one word, both targets compute the same merge.
    mem_wmerge #(.WIDTH(WIDTH)) u_w1 (
        .cur(mem[i1]),
        .mask1(bus.wmask1), .data1(bus.dataw1), .hit1(hit1),
        .mask2(bus.wmask2), .data2(bus.dataw2), .hit2(same),
        .word(w1_word)
    );

    mem_wmerge #(.WIDTH(WIDTH)) u_w2 (
        .cur(mem[i2]),
        .mask1(bus.wmask1), .data1(bus.dataw1), .hit1(same),
        .mask2(bus.wmask2), .data2(bus.dataw2), .hit2(hit2),
        .word(w2_word)
    );

    // Write-first read bypass.
    mem_wmerge #(.WIDTH(WIDTH)) u_ra (
        .cur(mem[ia]),
        .mask1(bus.wmask1), .data1(bus.dataw1), .hit1(hit1 && (i1 == ia)),
        .mask2(bus.wmask2), .data2(bus.dataw2), .hit2(hit2 && (i2 == ia)),
        .word(ra_word)
    );

    mem_wmerge #(.WIDTH(WIDTH)) u_rb (
        .cur(mem[ib]),
        .mask1(bus.wmask1), .data1(bus.dataw1), .hit1(hit1 && (i1 == ib)),
        .mask2(bus.wmask2), .data2(bus.dataw2), .hit2(hit2 && (i2 == ib)),
        .word(rb_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + idx_t'(1);
                if (cnt_q == idx_t'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt_q] <= '0;
        end else begin
            if (hit1) mem[i1] <= w1_word;
            if (hit2) mem[i2] <= w2_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outa_q   <= '0;
            outb_q   <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (!run) begin
            valida_q <= 1'b0;
            validb_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valida_q <= bus.rena;
            validb_q <= bus.renb;
            if (bus.rena) outa_q <= oka ? ra_word : '0;
            if (bus.renb) outb_q <= okb ? rb_word : '0;
            err_q <= (bus.wen1 && !ok1) || (bus.wen2 && !ok2)
                  || (bus.rena && !oka) || (bus.renb && !okb);
        end
    end

    assign bus.outa   = outa_q;
    assign bus.outb   = outb_q;
    assign bus.valida = valida_q;
    assign bus.validb = validb_q;
    assign bus.err    = err_q;
    assign bus.ready  = run;

endmodule
